// File: rtl/if_pc_sel.sv
// Fetch-stage next-PC generator for a 2-wide front end: holds the fetch PC and picks the next PC.
// Latency: outputs are combinational from the PC register; the PC updates on the next clk edge.
// Backpressure: ID_stall holds the presented group steady until decode accepts it.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   Imem_valid         I-cache data for Imem_addr is present this cycle
//   ID_stall           decode cannot take the current fetch group
//   ROB_mispredict     redirect request; ROB_target_pc is the corrected PC
//   BP_ptaken          per-slot taken bit from the combinational predictor
//   BP_paddress        per-slot predicted target, slot k at [64*k +: 64]
//   Imem_addr          8-byte aligned fetch address
//   IF_PC, IF_NPC      per-slot PC and PC+4; IF_NPC feeds the predictor
//   IF_valid           per-slot valid to decode
//   fetch_cnt          instructions accepted by decode (saturating)
//   redirect_cnt       mispredict redirects taken (saturating)
module if_pc_sel #(
    parameter int          SCALAR   = 2,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Imem_valid,
    input  logic                     ID_stall,
    input  logic                     ROB_mispredict,
    input  logic [63:0]              ROB_target_pc,
    input  logic [SCALAR-1:0]        BP_ptaken,
    input  logic [64*SCALAR-1:0]     BP_paddress,
    output logic [63:0]              Imem_addr,
    output logic [64*SCALAR-1:0]     IF_PC,
    output logic [64*SCALAR-1:0]     IF_NPC,
    output logic [SCALAR-1:0]        IF_valid,
    output logic [CNT_W-1:0]         fetch_cnt,
    output logic [CNT_W-1:0]         redirect_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [63:0] pc_seq;
    logic [63:0] bp_tgt0;
    logic [63:0] bp_tgt1;
    logic        slot1_vld;
    logic        slot2_vld;
    logic        advance;
    logic [1:0]  grp_cnt;
    logic [CNT_W:0]   fetch_sum;
    logic [CNT_W:0]   redirect_sum;
    logic [CNT_W-1:0] fetch_cnt_nxt;
    logic [CNT_W-1:0] redirect_cnt_nxt;

    assign bp_tgt0 = BP_paddress[63:0];
    assign bp_tgt1 = BP_paddress[127:64];

    // Sequential fetch moves to the next aligned 8-byte group; the carry
    // out of bit 63 is dropped so the PC wraps naturally.
    assign pc_seq = {pc[63:3] + 61'd1, 3'b000};

    // Reset gates the valids so nothing leaks to decode during a reset cycle.
    // An odd PC (pc[2]=1) is a single-instruction group, and a taken slot1
    // kills slot2 because slot2 lies on the wrong path.
    assign slot1_vld = ~reset & (state == ST_RUN) & Imem_valid;
    assign slot2_vld = slot1_vld & ~pc[2] & ~BP_ptaken[0];
    assign advance   = slot1_vld & ~ID_stall;
    assign grp_cnt   = {1'b0, slot1_vld} + {1'b0, slot2_vld};

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;

        case (state)
            ST_RUN:      if (!Imem_valid) state_nxt = ST_WAIT_MEM;
            // The returning-data cycle is spent re-entering RUN; the group
            // is presented on the following cycle.
            ST_WAIT_MEM: if (Imem_valid) state_nxt = ST_RUN;
            ST_REDIRECT: state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase

        if (advance) begin
            if (BP_ptaken[0]) begin
                pc_nxt = bp_tgt0;
            end else if (slot2_vld && BP_ptaken[1]) begin
                pc_nxt = bp_tgt1;
            end else begin
                pc_nxt = pc_seq;
            end
        end

        // A redirect beats both advance and any stall or memory wait.
        if (ROB_mispredict) begin
            pc_nxt    = ROB_target_pc;
            state_nxt = ST_REDIRECT;
        end
    end

    // Counters are one bit wider internally so overflow can be detected
    // and clamped to all-ones.
    assign fetch_sum    = {1'b0, fetch_cnt} + {{(CNT_W-1){1'b0}}, grp_cnt};
    assign redirect_sum = {1'b0, redirect_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        fetch_cnt_nxt    = fetch_cnt;
        redirect_cnt_nxt = redirect_cnt;
        // An accepted group is counted even when a redirect wins the PC.
        if (advance) begin
            fetch_cnt_nxt = fetch_sum[CNT_W] ? {CNT_W{1'b1}} : fetch_sum[CNT_W-1:0];
        end
        if (ROB_mispredict) begin
            redirect_cnt_nxt = redirect_sum[CNT_W] ? {CNT_W{1'b1}} : redirect_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            pc           <= RESET_PC;
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            fetch_cnt    <= fetch_cnt_nxt;
            redirect_cnt <= redirect_cnt_nxt;
        end
    end

    assign Imem_addr = {pc[63:3], 3'b000};
    assign IF_PC     = {pc + 64'd4, pc};
    assign IF_NPC    = {pc + 64'd8, pc + 64'd4};
    assign IF_valid  = {slot2_vld, slot1_vld};

endmodule
